// File: rtl/seq_det_pkg.sv
// Pattern-matching helpers shared by the round-robin sequence detector.
// All functions are pure combinational; the pattern is left-aligned so bit len-1 is the first bit received.
package seq_det_pkg;

    localparam int PAT_LEN_MAX = 8;
    localparam int ST_W        = $clog2(PAT_LEN_MAX + 1);
    localparam int PI_W        = $clog2(PAT_LEN_MAX);

    typedef logic [ST_W-1:0]        st_t;
    typedef logic [PAT_LEN_MAX-1:0] pat_t;

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic st_t border_len(input pat_t pattern, input int len);
        st_t  res;
        logic ok;
        res = '0;
        for (int k = 1; k < PAT_LEN_MAX; k++) begin
            if (k < len) begin
                ok = 1'b1;
                for (int j = 0; j < PAT_LEN_MAX; j++) begin
                    if (j < k && pattern[PI_W'(len - 1 - j)] != pattern[PI_W'(k - 1 - j)])
                        ok = 1'b0;
                end
                if (ok)
                    res = ST_W'(k);
            end
        end
        return res;
    endfunction

    // Longest pattern prefix that is a suffix of (prefix(state) ++ b).
    // state must be below len; the caller folds the detect state back first.
    function automatic st_t pat_step(input st_t state, input logic b,
                                     input pat_t pattern, input int len);
        st_t  res;
        logic ok;
        logic sb;
        int   idx;
        int   s;
        res = '0;
        s   = int'(state);
        for (int k = 1; k <= PAT_LEN_MAX; k++) begin
            if (k <= s + 1 && k <= len) begin
                ok = 1'b1;
                for (int j = 0; j < PAT_LEN_MAX; j++) begin
                    if (j < k) begin
                        idx = s + 1 - k + j;
                        sb  = (idx == s) ? b : pattern[PI_W'(len - 1 - idx)];
                        if (sb != pattern[PI_W'(len - 1 - j)])
                            ok = 1'b0;
                    end
                end
                if (ok)
                    res = ST_W'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from the eligible vector, searched from r_ptr.
// The pointer moves to one past the winner on every grant and holds when nothing is granted.
module seq_det_rr_arb #(
    parameter  int N_CH  = 4,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  i_elig,
    output logic [N_CH-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    logic [IDX_W-1:0] r_ptr;
    int               w_c;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_c       = 0;
        for (int k = 0; k < N_CH; k++) begin
            w_c = int'(r_ptr) + k;
            if (w_c >= N_CH)
                w_c = w_c - N_CH;
            if (!o_gnt_vld && i_elig[IDX_W'(w_c)]) begin
                o_gnt_vld              = 1'b1;
                o_gnt_idx              = IDX_W'(w_c);
                o_gnt[IDX_W'(w_c)]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_gnt_vld) begin
            if (o_gnt_idx == IDX_W'(N_CH - 1))
                r_ptr <= '0;
            else
                r_ptr <= o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_rr_scheduler.sv
// N_CH serial channels share one Moore pattern-detector step; one granted bit per cycle, round-robin.
// det_valid/det_ch are registered, one clock after the winning transfer; req_ready is the combinational grant.
module seq_det_rr_scheduler
    import seq_det_pkg::*;
#(
    parameter  int                 N_CH    = 4,
    parameter  int                 PAT_LEN = 4,
    parameter  logic [PAT_LEN-1:0] PATTERN = 4'b1100,
    parameter  int                 OVERLAP = 0,
    parameter  int                 CNT_W   = 8,
    localparam int                 CH_W    = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH-1:0]       clr_ch,
    input  logic [N_CH-1:0]       req_valid,
    input  logic [N_CH-1:0]       req_bit,
    output logic [N_CH-1:0]       req_ready,
    output logic                  det_valid,
    output logic [CH_W-1:0]       det_ch,
    output logic [N_CH*CNT_W-1:0] hit_count
);

    localparam pat_t             PAT_EXT    = pat_t'(PATTERN);
    localparam st_t              ST_DET     = st_t'(PAT_LEN);
    localparam st_t              ST_RESTART = (OVERLAP != 0) ? border_len(PAT_EXT, PAT_LEN) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [N_CH-1:0]  w_elig;
    logic [N_CH-1:0]  w_gnt;
    logic [CH_W-1:0]  w_gnt_idx;
    logic             w_gnt_vld;
    st_t              w_cur;
    st_t              w_seff;
    st_t              w_nxt;
    logic             w_hit;

    st_t              r_st  [N_CH];
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic             r_det_vld;
    logic [CH_W-1:0]  r_det_ch;

    // Reset also masks eligibility so no grant is visible while rst is held.
    assign w_elig = {N_CH{en & ~rst}} & req_valid & ~clr_ch;

    seq_det_rr_arb #(
        .N_CH (N_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_elig    (w_elig),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    assign req_ready = w_gnt;

    assign w_cur  = r_st[w_gnt_idx];
    assign w_seff = (w_cur == ST_DET) ? ST_RESTART : w_cur;
    assign w_nxt  = pat_step(w_seff, req_bit[w_gnt_idx], PAT_EXT, PAT_LEN);
    assign w_hit  = w_gnt_vld && (w_nxt == ST_DET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_st[c]  <= '0;
                r_cnt[c] <= '0;
            end
            r_det_vld <= 1'b0;
            r_det_ch  <= '0;
        end else begin
            r_det_vld <= w_hit;
            if (w_hit)
                r_det_ch <= w_gnt_idx;
            for (int c = 0; c < N_CH; c++) begin
                if (clr_ch[c]) begin
                    r_st[c]  <= '0;
                    r_cnt[c] <= '0;
                end else if (w_gnt_vld && w_gnt_idx == CH_W'(c)) begin
                    r_st[c] <= w_nxt;
                    if (w_hit && r_cnt[c] != CNT_MAX)
                        r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    assign det_valid = r_det_vld;
    assign det_ch    = r_det_ch;

    always_comb begin
        hit_count = '0;
        for (int c = 0; c < N_CH; c++)
            hit_count[c*CNT_W +: CNT_W] = r_cnt[c];
    end

endmodule

// File: tb/tb_seq_det_rr_scheduler.sv
// Bench for seq_det_rr_scheduler: directed vector tables, hand-written corner sequences,
// and a random run against a history-queue model of the detector and round-robin grant.
module tb_seq_det_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  clr_ch;
    logic [3:0]  req_valid;
    logic [3:0]  req_bit;

    logic [3:0]  req_ready;
    logic        det_valid;
    logic [1:0]  det_ch;
    logic [31:0] hit_count;

    logic [3:0]  rdy_ov, rdy_no;
    logic        dv_ov, dv_no;
    logic [1:0]  dc_ov, dc_no;
    logic [7:0]  hc_ov, hc_no;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_det_rr_scheduler dut (
        .clk(clk), .rst(rst), .en(en), .clr_ch(clr_ch), .req_valid(req_valid), .req_bit(req_bit),
        .req_ready(req_ready), .det_valid(det_valid), .det_ch(det_ch), .hit_count(hit_count)
    );

    seq_det_rr_scheduler #(.PATTERN(4'b1010), .OVERLAP(1), .CNT_W(2)) dut_ov (
        .clk(clk), .rst(rst), .en(en), .clr_ch(clr_ch), .req_valid(req_valid), .req_bit(req_bit),
        .req_ready(rdy_ov), .det_valid(dv_ov), .det_ch(dc_ov), .hit_count(hc_ov)
    );

    seq_det_rr_scheduler #(.PATTERN(4'b1010), .OVERLAP(0), .CNT_W(2)) dut_no (
        .clk(clk), .rst(rst), .en(en), .clr_ch(clr_ch), .req_valid(req_valid), .req_bit(req_bit),
        .req_ready(rdy_no), .det_valid(dv_no), .det_ch(dc_no), .hit_count(hc_no)
    );

    typedef struct {
        logic       en;
        logic [3:0] vld;
        logic [3:0] bits;
        logic [3:0] clr;
        logic [3:0] rdy;
        logic       det;
        logic [1:0] ch;
    } vec_t;

    vec_t tv[$];

    // Reference model state
    int         m_ptr;
    bit         hq[4][$];
    int         mcnt[4];
    logic       exp_dv;
    logic [1:0] exp_dc;
    logic [3:0] pat_v = 4'b1100;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        en = e; req_valid = v; req_bit = b; clr_ch = c;
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; req_valid = '0; req_bit = '0; clr_ch = '0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        m_ptr = 0; exp_dv = 1'b0; exp_dc = '0;
        for (int c = 0; c < 4; c++) begin
            hq[c].delete();
            mcnt[c] = 0;
        end
    endtask

    function automatic void addv(logic e, logic [3:0] v, logic [3:0] b, logic [3:0] c,
                                 logic [3:0] r, logic d, logic [1:0] ch);
        vec_t t;
        t.en = e; t.vld = v; t.bits = b; t.clr = c; t.rdy = r; t.det = d; t.ch = ch;
        tv.push_back(t);
    endfunction

    task automatic run_table(input string nm);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].en, tv[i].vld, tv[i].bits, tv[i].clr);
            check({nm, "_rdy"}, 64'(req_ready), 64'(tv[i].rdy));
            tick();
            check({nm, "_det"}, 64'(det_valid), 64'(tv[i].det));
            if (tv[i].det)
                check({nm, "_ch"}, 64'(det_ch), 64'(tv[i].ch));
        end
        tv.delete();
    endtask

    initial begin
        logic [3:0] b1;
        int         g;
        int         pulses;
        logic [3:0] exp_rdy;
        bit         match;

        do_reset();
        check("rst_det_valid", 64'(det_valid), 64'd0);
        check("rst_det_ch", 64'(det_ch), 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        tick();

        // Test 1: ch0 alone, 11001100
        b1 = 4'b1100;
        for (int i = 0; i < 8; i++)
            addv(1'b1, 4'b0001, {3'b000, b1[2'(3 - (i % 4))]}, 4'b0000, 4'b0001, (i == 3 || i == 7), 2'd0);
        run_table("t1");
        check("t1_hc0", 64'(hit_count[7:0]), 64'd2);

        // Test 2: all valid, ch2 fed 1100 on its grants
        do_reset(); tick();
        for (int i = 0; i < 16; i++)
            addv(1'b1, 4'b1111, (i <= 6) ? 4'b0100 : 4'b0000, 4'b0000,
                 4'(1 << (i % 4)), (i == 14), 2'd2);
        run_table("t2");
        check("t2_hc", 64'(hit_count), 64'h0001_0000);

        // Test 3: interleave ch1/ch3
        do_reset(); tick();
        addv(1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0);
        addv(1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0);
        addv(1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0);
        addv(1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0);
        addv(1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0);
        addv(1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1);
        addv(1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0);
        run_table("t3");
        check("t3_hc1", 64'(hit_count[15:8]), 64'd1);
        check("t3_hc3", 64'(hit_count[31:24]), 64'd0);
        check("t3_ch_hold", 64'(det_ch), 64'd1);

        // Test 4: clear ch1 while it sits in S3
        do_reset(); tick();
        b1 = 4'b1100;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 4'b0010, {2'b00, b1[2'(3 - (i % 4))], 1'b0}, 4'b0000);
            tick();
        end
        check("t4_hc1_pre", 64'(hit_count[15:8]), 64'd1);
        drive(1'b1, 4'b0010, 4'b0000, 4'b0010);
        check("t4_clr_rdy", 64'(req_ready), 64'd0);
        tick();
        check("t4_hc1_clr", 64'(hit_count[15:8]), 64'd0);
        drive(1'b1, 4'b0010, 4'b0000, 4'b0000);
        check("t4_rdy", 64'(req_ready), 64'b0010);
        tick();
        check("t4_nohit", 64'(det_valid), 64'd0);
        check("t4_hc1_post", 64'(hit_count[15:8]), 64'd0);

        // Test 5: PATTERN 1010 overlapping vs not, then saturation of 2-bit counters
        do_reset(); tick();
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'b0001, {3'b000, ~i[0]}, 4'b0000);
            tick();
            if (dv_ov) pulses++;
            if (i == 5) begin
                check("t5_ov_hits", 64'(hc_ov[1:0]), 64'd2);
                check("t5_no_hits", 64'(hc_no[1:0]), 64'd1);
                check("t5_ov_pulses", 64'(pulses), 64'd2);
            end
        end
        check("t5_ov_sat", 64'(hc_ov[1:0]), 64'd3);
        check("t5_no_sat", 64'(hc_no[1:0]), 64'd3);
        check("t5_ov_pulses_all", 64'(pulses), 64'd7);

        // Test 6: asynchronous reset between edges
        do_reset(); tick();
        b1 = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0001, {3'b000, b1[2'(3 - i)]}, 4'b0000);
            tick();
        end
        check("t6_det_pre", 64'(det_valid), 64'd1);
        drive(1'b1, 4'b1001, 4'b0000, 4'b0000);
        check("t6_rdy_pre", 64'(req_ready), 64'b1000);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_det", 64'(det_valid), 64'd0);
        check("t6_rst_hc", 64'(hit_count), 64'd0);
        check("t6_rst_rdy", 64'(req_ready), 64'd0);
        #1 rst = 1'b0;
        #1;
        check("t6_rdy_post", 64'(req_ready), 64'b0001);
        tick();

        // Random run against the model
        do_reset(); tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en        = ($urandom_range(0, 9) != 0);
            req_valid = 4'($urandom);
            req_bit   = 4'($urandom);
            for (int c = 0; c < 4; c++)
                clr_ch[c] = ($urandom_range(0, 19) == 0);
            g = -1;
            if (en)
                for (int k = 0; k < 4; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % 4] && !clr_ch[(m_ptr + k) % 4])
                        g = (m_ptr + k) % 4;
            exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
            #1;
            check("rnd_rdy", 64'(req_ready), 64'(exp_rdy));
            tick();
            exp_dv = 1'b0;
            for (int c = 0; c < 4; c++)
                if (clr_ch[c]) begin
                    hq[c].delete();
                    mcnt[c] = 0;
                end
            if (g >= 0) begin
                hq[g].push_back(req_bit[2'(g)]);
                if (hq[g].size() > 4)
                    void'(hq[g].pop_front());
                if (hq[g].size() == 4) begin
                    match = 1'b1;
                    for (int j = 0; j < 4; j++)
                        if (hq[g][j] != pat_v[2'(3 - j)]) match = 1'b0;
                    if (match) begin
                        exp_dv = 1'b1;
                        exp_dc = 2'(g);
                        if (mcnt[g] < 255) mcnt[g]++;
                        hq[g].delete();
                    end
                end
                m_ptr = (g + 1) % 4;
            end
            check("rnd_det", 64'(det_valid), 64'(exp_dv));
            check("rnd_ch", 64'(det_ch), 64'(exp_dc));
            for (int c = 0; c < 4; c++)
                check("rnd_hc", 64'(hit_count[c*8 +: 8]), 64'(mcnt[c]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
